// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 multiplier: field widths, special
// encodings, controller state encoding and the binary32 field layout.
package fp_pkg;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    // Significand with hidden bit, double-width product, signed exponent sum
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned ESUM_W = 10;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MUL,
        NORM,
        ROUND,
        DONE
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    // Exponent field of all ones
    function automatic logic exp_all_ones(input fp32_t x);
        return x.exp == EXP_W'(EXP_MAX);
    endfunction

endpackage

// File: rtl/mant_mul_serial.sv
// Iterative 24x24 unsigned multiplier retiring BITS_PER_CYCLE multiplier
// bits per cycle into a 48-bit product.
// Ports: clk, rst (sync, active-high), start (load operands, clear product),
//        mcand/mplier (24-bit significands), busy (steps in progress),
//        done (one-cycle pulse after the last step), product (48-bit, held
//        stable once done).
module mant_mul_serial
    import fp_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIG_W-1:0]  mcand,
    input  logic [SIG_W-1:0]  mplier,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    localparam int unsigned N = SIG_W / BITS_PER_CYCLE;

    logic [PROD_W-1:0] mcand_sh;
    logic [SIG_W-1:0]  mplier_sh;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] partial;

    // Partial product of the shifted multiplicand and the current digit
    always_comb begin
        partial = '0;
        partial = mcand_sh * PROD_W'(mplier_sh[BITS_PER_CYCLE-1:0]);
    end

    // Shift-add step sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            product   <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy      <= 1'b1;
                cnt       <= '0;
                product   <= '0;
                mcand_sh  <= PROD_W'(mcand);
                mplier_sh <= mplier;
            end else if (busy) begin
                product   <= product + partial;
                mcand_sh  <= mcand_sh << BITS_PER_CYCLE;
                mplier_sh <= mplier_sh >> BITS_PER_CYCLE;
                cnt       <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(N - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fp_mul_sequencer.sv
// Multi-cycle binary32 multiplier controller: accepts an operand pair,
// screens special operands, runs the serial significand multiply, then
// normalizes, rounds to nearest even and returns the packed result.
// Ports: clk, rst (sync, active-high);
//        Valid_in/In_ready/Op_A/Op_B  - operand handshake;
//        Valid_out/Out_ready/Resultado - result handshake;
//        Overflow/Underflow/Invalid    - flags, valid with Valid_out.
module fp_mul_sequencer
    import fp_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Valid_in,
    output logic        In_ready,
    input  logic [31:0] Op_A,
    input  logic [31:0] Op_B,
    output logic        Valid_out,
    input  logic        Out_ready,
    output logic [31:0] Resultado,
    output logic        Overflow,
    output logic        Underflow,
    output logic        Invalid
);

    localparam int unsigned N = SIG_W / BITS_PER_CYCLE;
    localparam logic signed [ESUM_W-1:0] E_TOP  = ESUM_W'(EXP_MAX);
    localparam logic signed [ESUM_W-1:0] E_ZERO = '0;

    state_t                    state;
    fp32_t                     op_a;
    fp32_t                     op_b;
    logic                      sign_r;
    logic signed [ESUM_W-1:0]  exp_r;
    logic [PROD_W-3:0]         prod_r;
    logic                      sticky_r;
    logic [CNT_W-1:0]          mul_cnt;

    logic                      mul_start_c;
    logic                      mul_busy;
    logic                      mul_done;
    logic [PROD_W-1:0]         mul_prod;

    logic                      sign_c;
    logic                      a_zero_c, b_zero_c;
    logic                      a_inf_c, b_inf_c;
    logic                      invalid_c, inf_c, zero_c;
    logic                      round_up_c;
    logic [SIG_W-1:0]          mant_rnd_c;
    logic signed [ESUM_W-1:0]  exp_rnd_c;

    // Operand classification (exponent 0 counts as zero: denormals flush)
    always_comb begin
        sign_c    = op_a.sign ^ op_b.sign;
        a_zero_c  = op_a.exp == '0;
        b_zero_c  = op_b.exp == '0;
        a_inf_c   = exp_all_ones(op_a) && (op_a.frac == '0);
        b_inf_c   = exp_all_ones(op_b) && (op_b.frac == '0);
        invalid_c = (exp_all_ones(op_a) && (op_a.frac != '0)) ||
                    (exp_all_ones(op_b) && (op_b.frac != '0)) ||
                    (a_inf_c && b_zero_c) || (b_inf_c && a_zero_c);
        inf_c     = a_inf_c || b_inf_c;
        zero_c    = a_zero_c || b_zero_c;
        mul_start_c = (state == UNPACK) && !invalid_c && !inf_c && !zero_c;
    end

    // Round to nearest even on the normalized product (leading 1 at bit 46)
    always_comb begin
        round_up_c = prod_r[MAN_W-1] &&
                     ((|prod_r[MAN_W-2:0]) || sticky_r || prod_r[MAN_W]);
        mant_rnd_c = {1'b0, prod_r[PROD_W-3:MAN_W]} + SIG_W'(round_up_c);
        // Carry out of the fraction leaves it all zero; bump the exponent
        exp_rnd_c  = exp_r + ESUM_W'(mant_rnd_c[MAN_W]);
    end

    mant_mul_serial #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_mant_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_c),
        .mcand   ({1'b1, op_a.frac}),
        .mplier  ({1'b1, op_b.frac}),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Controller state, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            In_ready  <= 1'b0;
            Valid_out <= 1'b0;
            Resultado <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            Invalid   <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            prod_r    <= '0;
            sticky_r  <= 1'b0;
            mul_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    In_ready <= 1'b1;
                    if (Valid_in && In_ready) begin
                        op_a     <= Op_A;
                        op_b     <= Op_B;
                        In_ready <= 1'b0;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_r <= sign_c;
                    if (invalid_c) begin
                        Resultado <= QNAN;
                        Invalid   <= 1'b1;
                        Valid_out <= 1'b1;
                        state     <= DONE;
                    end else if (inf_c) begin
                        Resultado <= {sign_c, EXP_W'(EXP_MAX), MAN_W'(0)};
                        Valid_out <= 1'b1;
                        state     <= DONE;
                    end else if (zero_c) begin
                        Resultado <= {sign_c, 31'd0};
                        Valid_out <= 1'b1;
                        state     <= DONE;
                    end else begin
                        exp_r   <= $signed(ESUM_W'(op_a.exp) + ESUM_W'(op_b.exp)
                                           - ESUM_W'(BIAS));
                        mul_cnt <= '0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (mul_busy) begin
                        mul_cnt <= mul_cnt + CNT_W'(1);
                    end
                    if (mul_cnt == CNT_W'(N - 1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mul_done) begin
                        if (mul_prod[PROD_W-1]) begin
                            prod_r   <= mul_prod[PROD_W-2:1];
                            sticky_r <= mul_prod[0];
                            exp_r    <= exp_r + ESUM_W'(1);
                        end else begin
                            prod_r   <= mul_prod[PROD_W-3:0];
                            sticky_r <= 1'b0;
                        end
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (exp_rnd_c >= E_TOP) begin
                        Resultado <= {sign_r, EXP_W'(EXP_MAX), MAN_W'(0)};
                        Overflow  <= 1'b1;
                    end else if (exp_rnd_c <= E_ZERO) begin
                        Resultado <= {sign_r, 31'd0};
                        Underflow <= 1'b1;
                    end else begin
                        Resultado <= {sign_r, exp_rnd_c[EXP_W-1:0], mant_rnd_c[MAN_W-1:0]};
                    end
                    Valid_out <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (Valid_out && Out_ready) begin
                        Valid_out <= 1'b0;
                        Resultado <= '0;
                        Overflow  <= 1'b0;
                        Underflow <= 1'b0;
                        Invalid   <= 1'b0;
                        In_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Self-checking bench: a 1-bit/cycle and a 4-bit/cycle instance driven with
// a table of directed vectors plus hand-written hold and abort sequences.
module tb_fp_mul_sequencer;

    logic clk;
    logic rst;
    logic [1:0]       vin, in_rdy, vout, ordy, ovf, unf, inv;
    logic [1:0][31:0] opa, opb, res;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flags;   // {Overflow, Underflow, Invalid}
        int          lat;
    } vec_t;

    vec_t vecs[15];

    fp_mul_sequencer #(.BITS_PER_CYCLE(1)) dut_b1 (
        .clk(clk), .rst(rst),
        .Valid_in(vin[0]), .In_ready(in_rdy[0]), .Op_A(opa[0]), .Op_B(opb[0]),
        .Valid_out(vout[0]), .Out_ready(ordy[0]), .Resultado(res[0]),
        .Overflow(ovf[0]), .Underflow(unf[0]), .Invalid(inv[0])
    );

    fp_mul_sequencer #(.BITS_PER_CYCLE(4)) dut_b4 (
        .clk(clk), .rst(rst),
        .Valid_in(vin[1]), .In_ready(in_rdy[1]), .Op_A(opa[1]), .Op_B(opb[1]),
        .Valid_out(vout[1]), .Out_ready(ordy[1]), .Resultado(res[1]),
        .Overflow(ovf[1]), .Underflow(unf[1]), .Invalid(inv[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for In_ready, present the operands, return just after the accept edge
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (!in_rdy[d] && w < 100) begin
            tick();
            w++;
        end
        check($sformatf("dut%0d_in_ready_wait", d), 32'(in_rdy[d]), 32'd1);
        vin[d] = 1'b1;
        opa[d] = a;
        opb[d] = b;
        tick();
        vin[d] = 1'b0;
    endtask

    // Count edges after accept until Valid_out is seen (bounded)
    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (!vout[d] && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    // Output handshake; In_ready and cleared flags expected right after it
    task automatic release_out(input int d, input string name);
        ordy[d] = 1'b1;
        tick();
        ordy[d] = 1'b0;
        check({name, "_vout_after_hs"}, 32'(vout[d]), 32'd0);
        check({name, "_flags_after_hs"}, 32'({ovf[d], unf[d], inv[d]}), 32'd0);
        check({name, "_in_ready_after_hs"}, 32'(in_rdy[d]), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        issue(v.dut, v.a, v.b);
        wait_valid(v.dut, lat);
        check({name, "_latency"}, 32'(lat), 32'(v.lat));
        check({name, "_result"}, res[v.dut], v.res);
        check({name, "_flags"}, 32'({ovf[v.dut], unf[v.dut], inv[v.dut]}), 32'(v.flags));
        release_out(v.dut, name);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;

        vecs[0]  = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 27};
        vecs[1]  = '{0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 27};
        vecs[2]  = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 27};
        vecs[3]  = '{0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 27};
        vecs[4]  = '{0, 32'h3F800001, 32'h3FC00001, 32'h3FC00003, 3'b000, 27};
        vecs[5]  = '{0, 32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000, 27};
        vecs[6]  = '{0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, 27};
        vecs[7]  = '{0, 32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 27};
        vecs[8]  = '{0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001, 1};
        vecs[9]  = '{0, 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1};
        vecs[10] = '{0, 32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 1};
        vecs[11] = '{0, 32'h00000001, 32'h40000000, 32'h00000000, 3'b000, 1};
        vecs[12] = '{1, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 9};
        vecs[13] = '{1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 9};
        vecs[14] = '{1, 32'h3F800001, 32'h3FC00001, 32'h3FC00003, 3'b000, 9};

        rst  = 1'b1;
        vin  = '0;
        ordy = '0;
        opa  = '0;
        opb  = '0;

        // Reset state
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_reset_in_ready", d), 32'(in_rdy[d]), 32'd0);
            check($sformatf("dut%0d_reset_vout", d), 32'(vout[d]), 32'd0);
            check($sformatf("dut%0d_reset_result", d), res[d], 32'd0);
            check($sformatf("dut%0d_reset_flags", d), 32'({ovf[d], unf[d], inv[d]}), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("dut0_in_ready_after_reset", 32'(in_rdy[0]), 32'd1);
        check("dut1_in_ready_after_reset", 32'(in_rdy[1]), 32'd1);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Inf x 0 with Out_ready held low: output stable, new operands ignored
        issue(0, 32'h7F800000, 32'h00000000);
        wait_valid(0, lat);
        check("hold_latency", 32'(lat), 32'd1);
        for (int c = 0; c < 5; c++) begin
            vin[0] = 1'b1;
            opa[0] = 32'h40000000;
            opb[0] = 32'h40400000;
            tick();
            check($sformatf("hold%0d_vout", c), 32'(vout[0]), 32'd1);
            check($sformatf("hold%0d_result", c), res[0], 32'h7FC00000);
            check($sformatf("hold%0d_invalid", c), 32'(inv[0]), 32'd1);
            check($sformatf("hold%0d_in_ready", c), 32'(in_rdy[0]), 32'd0);
        end
        vin[0] = 1'b0;
        release_out(0, "hold");
        tick();
        check("hold_no_spurious_vout", 32'(vout[0]), 32'd0);

        // Reset in the 10th MUL cycle aborts the op without output
        issue(0, 32'h40000000, 32'h40400000);
        repeat (10) tick();
        check("abort_vout_before_rst", 32'(vout[0]), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_vout", 32'(vout[0]), 32'd0);
        check("abort_result", res[0], 32'd0);
        check("abort_flags", 32'({ovf[0], unf[0], inv[0]}), 32'd0);
        check("abort_in_ready_low", 32'(in_rdy[0]), 32'd0);
        tick();
        check("abort_in_ready_high", 32'(in_rdy[0]), 32'd1);
        check("abort_no_late_vout", 32'(vout[0]), 32'd0);
        run_vec(vecs[0], "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
